// File: rtl/mem_access_pkg.sv
// Shared types and constants for the data-memory access unit.
package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_RW_BOTH  = 2'd3;

  localparam int TIMEOUT_CYC_DEF = 16;
  localparam int DATA_W          = 32;
  // Wide enough for the largest legal TIMEOUT_CYC (255).
  localparam int CNT_W           = 8;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Bus wait-cycle counter; expired flags the last permitted wait cycle.
module mem_timeout_ctr
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Count reaches TIMEOUT_CYC on the edge that leaves this cycle.
  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between execute and a handshaked data-memory bus.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-3:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic [DATA_W-1:0] readdata,
  output logic              rd_valid,
  output logic              err,
  output logic [1:0]        err_code
);

  state_t     state_q, state_d;
  logic       accept;
  logic       op_illegal;
  logic [1:0] illegal_code;
  logic       tmo_clear, tmo_en, tmo_expired;
  logic       busy_stall;
  logic       is_load_q;

  assign accept       = valid_in & (memread | memwrite);
  assign illegal_code = (memread & memwrite)     ? ERR_RW_BOTH  :
                        (address[1:0] != 2'b00)  ? ERR_MISALIGN : ERR_NONE;
  assign op_illegal   = (illegal_code != ERR_NONE);

  mem_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmo_clear  = 1'b0;
    tmo_en     = 1'b0;
    busy_stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          busy_stall = 1'b1;
          tmo_clear  = 1'b1;
          state_d    = op_illegal ? ST_RESP : ST_BUSY;
        end
      end
      ST_BUSY: begin
        busy_stall = 1'b1;
        tmo_en     = ~bus_ack;
        if (bus_ack || tmo_expired) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall is combinational from valid_in, so it is forced low while in reset.
  assign stall = rst & busy_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      readdata  <= '0;
      rd_valid  <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      is_load_q <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      err      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            is_load_q <= memread;
            if (op_illegal) begin
              err      <= 1'b1;
              err_code <= illegal_code;
              readdata <= '0;
            end else begin
              bus_req   <= 1'b1;
              bus_we    <= memwrite;
              bus_addr  <= address[ADDR_W-1:2];
              bus_wdata <= writedata;
            end
          end
        end
        ST_BUSY: begin
          // An ack on the final wait cycle takes priority over the timeout.
          if (bus_ack) begin
            bus_req  <= 1'b0;
            err_code <= ERR_NONE;
            if (is_load_q) begin
              readdata <= bus_rdata;
              rd_valid <= 1'b1;
            end
          end else if (tmo_expired) begin
            bus_req  <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            readdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit with a transaction-level model.
module tb_mem_access_unit;

  localparam int TMO = 16;
  localparam int AW  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in, memread, memwrite;
  logic [AW-1:0] address;
  logic [31:0]   writedata;
  logic          stall, bus_req, bus_we;
  logic [AW-3:0] bus_addr;
  logic [31:0]   bus_wdata, bus_rdata, readdata;
  logic          bus_ack, rd_valid, err;
  logic [1:0]    err_code;

  mem_access_unit #(.TIMEOUT_CYC(TMO), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .memread(memread), .memwrite(memwrite),
    .address(address), .writedata(writedata), .stall(stall), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .readdata(readdata), .rd_valid(rd_valid), .err(err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rv;
    bit          er;
    logic [1:0]  code;
    logic [31:0] rdata;
    int          stall_len;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  // Current operation as seen by the memory side.
  bit          exp_legal = 1'b0;
  bit          exp_we = 1'b0;
  logic [29:0] exp_addr = '0;
  logic [31:0] exp_wdata = '0;
  int          ack_delay = 0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mdl_rd = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Memory responder: ack after ack_delay wait cycles, stray acks while idle.
  int bcnt = 0;
  always @(posedge clk) begin
    #1;
    if (bus_req) begin
      bus_ack   = (bcnt == ack_delay);
      bus_rdata = bus_ack ? mem_rdata : $urandom;
      bcnt++;
    end else begin
      bcnt      = 0;
      bus_ack   = ($urandom_range(0, 7) == 0);
      bus_rdata = $urandom;
    end
  end

  // Monitor: checks the bus each cycle and pops the scoreboard at each response.
  int          run = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] rd_hold = '0;
  logic [1:0]  code_hold = '0;
  always @(negedge clk) begin
    if (!rst) begin
      run        = 0;
      prev_stall = 1'b0;
      rd_hold    = '0;
      code_hold  = '0;
    end else begin
      if (bus_req) begin
        chk("bus_req_legal", 64'(exp_legal), 64'd1);
        chk("bus_we", 64'(bus_we), 64'(exp_we));
        chk("bus_addr", 64'(bus_addr), 64'(exp_addr));
        chk("bus_wdata", 64'(bus_wdata), 64'(exp_wdata));
      end
      if (prev_stall && !stall) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 64'(sb.size()), 64'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rd_valid", 64'(rd_valid), 64'(e.rv));
          chk("err", 64'(err), 64'(e.er));
          chk("err_code", 64'(err_code), 64'(e.code));
          chk("readdata", 64'(readdata), 64'(e.rdata));
          chk("resp_bus_req", 64'(bus_req), 64'd0);
          chk("stall_len", 64'(run), 64'(e.stall_len));
          rd_hold   = e.rdata;
          code_hold = e.code;
        end
        run = 0;
      end else begin
        chk("no_pulse", {62'd0, rd_valid, err}, 64'd0);
        chk("rd_hold", 64'(readdata), 64'(rd_hold));
        chk("code_hold", 64'(err_code), 64'(code_hold));
      end
      if (stall) run++;
      prev_stall = stall;
    end
  end

  task automatic wait_stall(input bit level);
    int n;
    n = 0;
    while (stall !== level && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) chk("stall_timeout", 64'(stall), 64'(level));
  endtask

  // Issue one operation; the expected response comes from the transaction rules.
  task automatic do_op(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input int dly, input logic [31:0] rdat);
    exp_t e;
    if (rd && wr) begin
      e = '{rv: 1'b0, er: 1'b1, code: 2'd3, rdata: 32'd0, stall_len: 1};
      mdl_rd = 32'd0;
    end else if (a[1:0] != 2'b00) begin
      e = '{rv: 1'b0, er: 1'b1, code: 2'd1, rdata: 32'd0, stall_len: 1};
      mdl_rd = 32'd0;
    end else if (dly >= TMO) begin
      e = '{rv: 1'b0, er: 1'b1, code: 2'd2, rdata: 32'd0, stall_len: 1 + TMO};
      mdl_rd = 32'd0;
    end else begin
      if (rd) mdl_rd = rdat;
      e = '{rv: rd, er: 1'b0, code: 2'd0, rdata: mdl_rd, stall_len: dly + 2};
    end
    sb.push_back(e);
    valid_in  = 1'b1;
    memread   = rd;
    memwrite  = wr;
    address   = a;
    writedata = wd;
    ack_delay = dly;
    mem_rdata = rdat;
    exp_legal = !(rd && wr) && (a[1:0] == 2'b00);
    exp_we    = wr;
    exp_addr  = a[31:2];
    exp_wdata = wd;
    #1;
    wait_stall(1'b1);
    @(posedge clk); #1;
    wait_stall(1'b0);
    valid_in = 1'b0;
  endtask

  task automatic idle_op();
    valid_in = 1'b1;
    memread  = 1'b0;
    memwrite = 1'b0;
    address  = $urandom;
    repeat (2) begin
      @(posedge clk); #1;
      chk("ignored_stall", 64'(stall), 64'd0);
    end
    valid_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; valid_in = 1'b1; memread = 1'b1; memwrite = 1'b0;
    address = 32'h10; writedata = '0; bus_ack = 1'b0; bus_rdata = '0;
    #3;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_outs", {bus_req, bus_we, rd_valid, err, err_code}, 64'd0);
    chk("rst_data", {bus_addr, readdata}, 64'd0);
    chk("rst_wdata", 64'(bus_wdata), 64'd0);
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    do_op(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'hDEADBEEF);
    do_op(1'b0, 1'b1, 32'h8, 32'h5, 4, 32'h0);
    do_op(1'b1, 1'b0, 32'h6, 32'h0, 0, 32'h12345678);
    do_op(1'b1, 1'b0, 32'h20, 32'h0, TMO + 3, 32'h11111111);
    do_op(1'b1, 1'b0, 32'h24, 32'h0, TMO - 1, 32'hCAFEF00D);
    do_op(1'b1, 1'b1, 32'h30, 32'h9, 0, 32'h0);
    idle_op();

    // Reset while a load waits on the bus.
    @(posedge clk); #1;
    valid_in = 1'b1; memread = 1'b1; memwrite = 1'b0; address = 32'h40;
    ack_delay = 1000; exp_legal = 1'b1; exp_we = 1'b0; exp_addr = 30'h10;
    exp_wdata = writedata;
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_bus_req", 64'(bus_req), 64'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_bus_req", 64'(bus_req), 64'd0);
    chk("async_rst_stall", 64'(stall), 64'd0);
    chk("async_rst_data", {err_code, readdata}, 64'd0);
    valid_in = 1'b0;
    mdl_rd = '0;
    sb.delete();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_op(1'b1, 1'b0, 32'h44, 32'h0, 1, 32'hA5A5A5A5);

    // Randomized operations.
    for (int i = 0; i < 150; i++) begin
      int          r, r2, dly;
      logic [31:0] a;
      r  = $urandom_range(0, 99);
      r2 = $urandom_range(0, 9);
      a  = $urandom & 32'hFFFF_FFFC;
      if (r2 < 7)       dly = $urandom_range(0, 5);
      else if (r2 == 7) dly = TMO - 1;
      else if (r2 == 8) dly = TMO;
      else              dly = TMO + $urandom_range(1, 5);
      if (r < 95 && r >= 85) begin
        do_op(1'b1, 1'b1, a, $urandom, dly, $urandom);
      end else if (r < 85) begin
        if ($urandom_range(0, 6) == 0) a[1:0] = 2'($urandom_range(1, 3));
        do_op(r < 45, r >= 45, a, $urandom, dly, $urandom);
      end else begin
        idle_op();
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: bus wait cycles before abort (range 2..255).
REQ-002 Parameter ADDR_W, default 32: byte-address width from execute.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 valid_in  input  1  execute presents a memory operation this cycle.
REQ-006 memread  input  1  operation is a load.
REQ-007 memwrite  input  1  operation is a store.
REQ-008 address  input  ADDR_W  byte address (ALU result).
REQ-009 writedata  input  32  store data (second register operand).
REQ-010 stall  output  1  upstream holds all inputs while high.
REQ-011 bus_req  output  1  data-memory request.
REQ-012 bus_we  output  1  request is a write.
REQ-013 bus_addr  output  ADDR_W-2  word address (address[ADDR_W-1:2]).
REQ-014 bus_wdata  output  32  write data.
REQ-015 bus_rdata  input  32  read data, valid with bus_ack.
REQ-016 bus_ack  input  1  one-cycle completion pulse from memory.
REQ-017 readdata  output  32  load result to writeback.
REQ-018 rd_valid  output  1  one-cycle pulse: readdata is new.
REQ-019 err  output  1  one-cycle pulse: operation aborted.
REQ-020 err_code  output  2  0 none, 1 misaligned, 2 timeout, 3 read+write both set; held until next operation completes.

Function
REQ-021 FSM states IDLE, BUSY, RESP; all bus outputs registered.
REQ-022 IDLE: valid_in & (memread|memwrite) accepts op; address/writedata/type latched; valid_in with neither flag ignored, stall low.
REQ-023 stall = (IDLE & accepting) | BUSY; low in RESP so upstream advances at end of RESP.
REQ-024 Legal op: IDLE->BUSY; bus_req, bus_we, bus_addr, bus_wdata held constant throughout BUSY.
REQ-025 BUSY with bus_ack: drop bus_req next edge, ->RESP; loads capture bus_rdata into readdata.
REQ-026 RESP: rd_valid=1 for loads only, err per REQ-027..029, ->IDLE; valid_in ignored in RESP.
REQ-027 address[1:0]!=0: no bus request, IDLE->RESP, err=1, err_code=1, readdata=0.
REQ-028 memread&memwrite: no bus request, IDLE->RESP, err=1, err_code=3, readdata=0.
REQ-029 Timeout counter cleared on BUSY entry, +1 per BUSY cycle without ack; reaching TIMEOUT_CYC: drop bus_req, ->RESP, err=1, err_code=2, readdata=0.
REQ-030 bus_ack on the same cycle as timeout: ack wins, normal completion.
REQ-031 bus_ack outside BUSY ignored; no state change.
REQ-032 Minimum latency: accept at cycle 0, bus_req cycles 1.., ack at cycle 1 -> RESP cycle 2; stall high cycles 0-1.
REQ-033 readdata holds its value between completions; stores leave it unchanged.

Reset
REQ-034 rst low immediately forces IDLE, counter 0, bus_req/bus_we/stall/rd_valid/err 0, bus_addr/bus_wdata/readdata 0, err_code 0.
REQ-035 Reset mid-BUSY abandons the transaction; no rd_valid/err pulse after release; first edge after release may accept.

Structure
REQ-036 Shared package mem_access_pkg: state enum, err_code constants, TIMEOUT_CYC default.
REQ-037 One sub-module mem_timeout_ctr (clear, enable, expired) holds the timeout counter.

Verification
REQ-038 Load 0x00000010, ack cycle 1, rdata 0xDEADBEEF -> bus_addr 0x4, rd_valid cycle 2, readdata 0xDEADBEEF, stall high cycles 0-1.
REQ-039 Store 0x8 data 0x5, ack after 4 wait cycles -> bus_we=1, wdata 0x5 stable 5 cycles, no rd_valid, err 0.
REQ-040 Load 0x6 -> no bus_req, err pulse, err_code 1, readdata 0.
REQ-041 Load, no ack for 16 cycles -> bus_req drops, err_code 2; then ack coinciding with 16th cycle -> normal completion.
REQ-042 memread=memwrite=1 -> err_code 3, no bus_req.
REQ-043 rst low during BUSY -> bus_req 0 asynchronously; next load after release completes normally.
